gray_counter_param: RTL

- Parametrised successor to the fixed 8-bit gray counter inside data_io: WIDTH-bit counter that counts up or down, loads a value, and can wrap or saturate.
- Presents gray-coded and binary values together.
- Terminal-count and wrap flags are used by downstream capture/IO logic and by async-boundary pointer logic.

---
 rtl/gray_counter_param.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gray_counter_param.sv
// ----------------------------------------------------------------------------
// gray_counter_param
//
// Purpose:
//   WIDTH-bit up/down counter with synchronous load and wrap or saturate
//   behaviour at the range ends. The binary count and its gray-coded
//   equivalent are held in separate registers that update on the same edge.
//   This keeps the two outputs aligned with no skew, and the gray value can
//   feed an async-boundary pointer directly.
//
// Parameters:
//   WIDTH      counter width in bits, 2..32
//   RESET_VAL  binary value loaded on reset, must be < 2**WIDTH
//
// Ports:
//   clk_i         rising-edge clock
//   reset_i       synchronous, active-high reset
//   enable_i      count enable, one step per cycle while high
//   up_dn_i       direction: 1 = up, 0 = down
//   sat_mode_i    1 = saturate at range ends, 0 = wrap modulo 2**WIDTH
//   load_i        synchronous load strobe, takes priority over enable_i
//   load_val_i    binary value written on load
//   value_gray_o  registered gray code of the count
//   value_bin_o   registered binary count
//   parity_o      registered XOR of value_gray_o (only with GRAYCNT_PARITY_EN)
//   tc_o          combinational terminal count: the next enabled step hits a range end
//   wrapped_o     registered one-cycle pulse while the post-wrap value is shown
//
// Optional feature:
//   Define GRAYCNT_PARITY_EN to add parity_o. If the macro is undefined, the
//   port and its logic are absent.
// ----------------------------------------------------------------------------
module gray_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             up_dn_i,
    input  logic             sat_mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] value_gray_o,
    output logic [WIDTH-1:0] value_bin_o,
`ifdef GRAYCNT_PARITY_EN
    output logic             parity_o,
`endif
    output logic             tc_o,
    output logic             wrapped_o
);

    localparam logic [WIDTH-1:0] AllOnes  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] Zero     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ResetBin = WIDTH'(RESET_VAL);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [WIDTH-1:0] ResetGray = to_gray(ResetBin);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    logic at_top;
    logic at_bottom;

    assign at_top    = (bin_q == AllOnes);
    assign at_bottom = (bin_q == Zero);

    // Next-state: load beats enable; a range end either wraps or holds.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load_i) begin
            bin_d = load_val_i;
        end else if (enable_i) begin
            if (up_dn_i) begin
                if (!at_top) begin
                    bin_d = bin_q + 1'b1;
                end else if (!sat_mode_i) begin
                    bin_d  = Zero;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_bottom) begin
                    bin_d = bin_q - 1'b1;
                end else if (!sat_mode_i) begin
                    bin_d  = AllOnes;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // The gray register is computed from the next binary value. It therefore
    // lands on the same edge as bin_q and adds no latency.
    always_comb begin
        gray_d = to_gray(bin_d);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bin_q  <= ResetBin;
            gray_q <= ResetGray;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef GRAYCNT_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            parity_q <= ^ResetGray;
        end else begin
            parity_q <= ^gray_d;
        end
    end

    assign parity_o = parity_q;
`endif

    // Terminal count ignores sat_mode_i. It flags the edge at which the count
    // would leave its range, whether that edge then wraps or saturates.
    always_comb begin
        tc_o = 1'b0;
        if (enable_i && !load_i) begin
            tc_o = up_dn_i ? at_top : at_bottom;
        end
    end

    assign value_bin_o  = bin_q;
    assign value_gray_o = gray_q;
    assign wrapped_o    = wrap_q;

    // The two count registers must always describe the same value.
    a_gray_matches_bin : assert property (@(posedge clk_i) gray_q == to_gray(bin_q));

endmodule
